// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_arbiter
// Purpose  : Round-robin arbiter and write sequencer for one shared WIDTH-bit
//            flip-flop register. Requesters own the register through a
//            req/gnt handshake. Each tenure lasts at most HOLD_MAX cycles.
//            A forced release is followed by a one-cycle grant bubble.
// Revision : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         we,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [NREQ-1:0]  ONE_HOT0   = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [WIDTH-1:0] wslice [NREQ];
  logic [IDX_W-1:0] owner_inc;
  logic [IDX_W-1:0] arb_start;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;

  // Split the flat write bus into per-requester slices
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign wslice[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Pointer value that follows the current owner, wrapping at NREQ-1
  assign owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  // On a voluntary handover the search starts just after the leaving owner,
  // which is also the value rr_ptr is about to take
  assign arb_start = (state == GRANT) ? owner_inc : rr_ptr;

  // Round-robin search: first asserted request at or after arb_start
  always_comb begin
    int pos;
    arb_found = 1'b0;
    arb_idx   = '0;
    pos       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(arb_start) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[pos[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = pos[IDX_W-1:0];
      end
    end
  end

  // Arbitration FSM with registered grant, owner and shared register update
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
    end else begin
      // gnt is one-hot on owner whenever non-zero, so owner selects the writer
      if (gnt[owner] && we[owner]) begin
        q       <= wslice[owner];
        q_valid <= 1'b1;
      end

      case (state)
        IDLE, GAP: begin
          if (arb_found) begin
            state    <= GRANT;
            gnt      <= ONE_HOT0 << arb_idx;
            owner    <= arb_idx;
            hold_cnt <= CNT_ONE;
          end else begin
            state    <= IDLE;
            gnt      <= '0;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (!req[owner]) begin
            rr_ptr <= owner_inc;
            if (arb_found) begin
              gnt      <= ONE_HOT0 << arb_idx;
              owner    <= arb_idx;
              hold_cnt <= CNT_ONE;
            end else begin
              state    <= IDLE;
              gnt      <= '0;
              hold_cnt <= '0;
            end
          end else if (hold_cnt < HOLD_LIMIT) begin
            hold_cnt <= hold_cnt + CNT_ONE;
          end else begin
            state    <= GAP;
            gnt      <= '0;
            rr_ptr   <= owner_inc;
            hold_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_bank_arbiter
// Purpose  : Directed self-checking bench for dff_bank_arbiter (4 x 8 bits,
//            HOLD_MAX = 4). Expected values are hand-derived constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;

  int n_tests;
  int n_fail;

  dff_bank_arbiter #(
    .NREQ     (4),
    .WIDTH    (8),
    .HOLD_MAX (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .wdata   (wdata),
    .gnt     (gnt),
    .owner   (owner),
    .q       (q),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge; inputs are driven and outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    we    = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Safety net in case the bench stalls
  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] order  [5];
    logic [3:0] forced [11];
    logic [3:0] oh;
    n_tests = 0;
    n_fail  = 0;

    order  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    forced = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
               4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};

    // 1: reset dominates requests and writes
    reset = 1'b0;
    req   = 4'b1111;
    we    = 4'b1111;
    wdata = 32'hFFEE_DDCC;
    @(negedge clk);
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qv", 32'(q_valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);

    // 2: single requester, write lands one edge after grant
    reset = 1'b1;
    req   = 4'b0001;
    we    = 4'b0001;
    wdata = 32'h0000_00A5;
    step();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_q_pre", 32'(q), 32'h0);
    chk("single_qv_pre", 32'(q_valid), 32'h0);
    step();
    chk("single_q", 32'(q), 32'hA5);
    chk("single_qv", 32'(q_valid), 32'h1);
    req = 4'b0000;
    we  = 4'b0000;
    step();
    chk("single_release", 32'(gnt), 32'h0);

    // 3: round-robin contention, two grant cycles per tenure, no bubbles
    do_reset();
    req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << order[i];
      chk($sformatf("rr%0d_c1", i), 32'(gnt), 32'(oh));
      req = 4'b1111;
      step();
      chk($sformatf("rr%0d_c2", i), 32'(gnt), 32'(oh));
      req = ~oh;
      step();
    end
    req = 4'b0000;
    step();

    // 4: forced release after HOLD_MAX cycles with one-cycle bubble
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 11; i++) begin
      step();
      chk($sformatf("forced%0d", i), 32'(gnt), 32'(forced[i]));
    end

    // 5: owner 0 writes, then an ungranted write from requester 2 is ignored
    we    = 4'b0001;
    wdata = 32'h0000_005A;
    step();
    chk("own_write_q", 32'(q), 32'h5A);
    we    = 4'b0100;
    wdata = 32'h003C_0000;
    step();
    chk("ungranted_q", 32'(q), 32'h5A);
    chk("ungranted_gnt", 32'(gnt), 32'h1);

    // 6: reset asserted mid-tenure drops the in-flight write
    do_reset();
    req = 4'b0010;
    step();
    chk("mid_gnt_pre", 32'(gnt), 32'h2);
    we    = 4'b0010;
    wdata = 32'h0000_7700;
    reset = 1'b0;
    step();
    chk("mid_rst_q", 32'(q), 32'h0);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_qv", 32'(q_valid), 32'h0);
    reset = 1'b1;
    we    = 4'b0000;
    req   = 4'b0010;
    step();
    chk("mid_regrant", 32'(gnt), 32'h2);
    chk("mid_owner", 32'(owner), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
